// File: rtl/cgra_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cgra_top: 4-tile coarse-grained reconfigurable array with 16-bit ALUs,   |
// | feed-forward tile routing and a selectable result bus.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cgra_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] config_addr,
  input  logic [31:0] config_data,
  input  logic [15:0] wire_0_m1_BUS16_S0_T0,
  input  logic [15:0] wire_m1_0_BUS16_S1_T0,
  input  logic [15:0] wire_1_m1_BUS16_S0_T2,
  input  logic [15:0] wire_2_0_BUS16_S3_T2,
  output logic [15:0] wire_0_1_BUS16_S0_T4
);

  localparam int          c_NUM_TILES = 4;
  localparam logic [15:0] c_GLOBAL_ID = 16'd4;
  localparam logic [7:0]  c_IDX_CFG   = 8'd0;
  localparam logic [7:0]  c_IDX_CONST = 8'd1;
  localparam logic [7:0]  c_IDX_OSEL  = 8'd0;

  logic [31:0] r_cfg   [c_NUM_TILES];
  logic [15:0] r_const [c_NUM_TILES];
  logic [15:0] r_out   [c_NUM_TILES];
  logic [1:0]  r_osel;

  logic [15:0]                  w_target_id;
  logic [7:0]                   w_reg_idx;
  logic [c_NUM_TILES-1:0][15:0] w_ext;
  logic [c_NUM_TILES-1:0][15:0] w_alu;
  logic [c_NUM_TILES-1:0][15:0] w_tile_out;
  logic                         w_unused_bits;

  assign w_target_id = config_addr[15:0];
  assign w_reg_idx   = config_addr[31:24];
  assign w_ext       = {wire_2_0_BUS16_S3_T2, wire_1_m1_BUS16_S0_T2,
                        wire_m1_0_BUS16_S1_T0, wire_0_m1_BUS16_S0_T0};

  function automatic logic [15:0] alu(input logic [3:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    alu = 16'h0000;
    case (op)
      4'd0: alu = a + b;
      4'd1: alu = a - b;
      4'd2: alu = a & b;
      4'd3: alu = a | b;
      4'd4: alu = a ^ b;
      4'd5: alu = a;
      4'd6: alu = (a > b) ? a : b;
      4'd7: alu = a * b;
      default: alu = 16'h0000;
    endcase
  endfunction

  // Tile sources only look at lower-numbered tiles, so routing can never loop.
  function automatic logic [15:0] src_sel(input logic [2:0] code,
                                          input logic [1:0] tile,
                                          input logic [15:0] cst,
                                          input logic [3:0][15:0] ext,
                                          input logic [3:0][15:0] outs);
    src_sel = 16'h0000;
    if (!code[2])
      src_sel = ext[code[1:0]];
    else if (code == 3'd7)
      src_sel = cst;
    else if (code[1:0] < tile)
      src_sel = outs[code[1:0]];
  endfunction

  always_comb begin
    logic [c_NUM_TILES-1:0][15:0] w_outs;
    logic [c_NUM_TILES-1:0][15:0] w_res;
    logic [15:0]                  w_a;
    logic [15:0]                  w_b;
    w_outs = '0;
    w_res  = '0;
    w_a    = '0;
    w_b    = '0;
    for (int i = 0; i < c_NUM_TILES; i++) begin
      w_a       = src_sel(r_cfg[i][2:0], 2'(i), r_const[i], w_ext, w_outs);
      w_b       = src_sel(r_cfg[i][5:3], 2'(i), r_const[i], w_ext, w_outs);
      w_res[i]  = alu(r_cfg[i][9:6], w_a, w_b);
      w_outs[i] = r_cfg[i][10] ? r_out[i] : w_res[i];
    end
    w_alu      = w_res;
    w_tile_out = w_outs;
  end

  for (genvar gi = 0; gi < c_NUM_TILES; gi++) begin : g_tile
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cfg[gi]   <= '0;
        r_const[gi] <= '0;
        r_out[gi]   <= '0;
      end else begin
        if (w_target_id == 16'(gi)) begin
          if (w_reg_idx == c_IDX_CFG)   r_cfg[gi]   <= config_data;
          if (w_reg_idx == c_IDX_CONST) r_const[gi] <= config_data[15:0];
        end
        r_out[gi] <= w_alu[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_osel <= '0;
    else if (w_target_id == c_GLOBAL_ID && w_reg_idx == c_IDX_OSEL)
      r_osel <= config_data[1:0];
  end

  assign wire_0_1_BUS16_S0_T4 = w_tile_out[r_osel];

  assign w_unused_bits = ^{config_addr[23:16], r_cfg[0][31:11], r_cfg[1][31:11],
                           r_cfg[2][31:11], r_cfg[3][31:11]};

endmodule
`default_nettype wire

// File: tb/tb_cgra_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cgra_top: directed vector table plus randomized runs of cgra_top      |
// | against a behavioural array model.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cgra_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [15:0] in0, in1, in2, in3;
  logic [15:0] dout;

  cgra_top dut (
    .clk                   (clk),
    .reset                 (reset),
    .config_addr           (config_addr),
    .config_data           (config_data),
    .wire_0_m1_BUS16_S0_T0 (in0),
    .wire_m1_0_BUS16_S1_T0 (in1),
    .wire_1_m1_BUS16_S0_T2 (in2),
    .wire_2_0_BUS16_S3_T2  (in3),
    .wire_0_1_BUS16_S0_T4  (dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain integers, evaluated tile by tile in id order.
  longint unsigned m_cfg[4];
  longint          m_const[4];
  longint          m_reg[4];
  longint          m_alu[4];
  longint          m_out[4];
  int              m_osel;

  function automatic longint m_src(int tile, int code);
    if (code < 4) begin
      case (code)
        0: return longint'(in0);
        1: return longint'(in1);
        2: return longint'(in2);
        default: return longint'(in3);
      endcase
    end
    if (code == 7) return m_const[tile];
    if (code - 4 < tile) return m_out[code - 4];
    return 0;
  endfunction

  task automatic model_eval();
    longint a, b, r;
    int op;
    for (int t = 0; t < 4; t++) begin
      a  = m_src(t, int'(m_cfg[t] % 8));
      b  = m_src(t, int'((m_cfg[t] / 8) % 8));
      op = int'((m_cfg[t] / 64) % 16);
      case (op)
        0: r = (a + b) % 65536;
        1: r = (a - b + 65536) % 65536;
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = a;
        6: r = (a > b) ? a : b;
        7: r = (a * b) % 65536;
        default: r = 0;
      endcase
      m_alu[t] = r;
      m_out[t] = ((m_cfg[t] / 1024) % 2 == 1) ? m_reg[t] : r;
    end
  endtask

  task automatic model_commit();
    longint unsigned id, idx;
    if (!reset) begin
      for (int t = 0; t < 4; t++) begin
        m_cfg[t] = 0; m_const[t] = 0; m_reg[t] = 0;
      end
      m_osel = 0;
    end else begin
      id  = longint'(config_addr) % 65536;
      idx = longint'(config_addr) / (1 << 24);
      if (id < 4 && idx == 0) m_cfg[id]   = longint'(config_data);
      if (id < 4 && idx == 1) m_const[id] = longint'(config_data) % 65536;
      if (id == 4 && idx == 0) m_osel     = int'(longint'(config_data) % 4);
      for (int t = 0; t < 4; t++) m_reg[t] = m_alu[t];
    end
  endtask

  function automatic logic [31:0] ad(int id, int idx);
    return {8'(idx), 8'h00, 16'(id)};
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change at negedge; the combinational output is sampled 1ns later.
  task automatic drive(bit rst_n, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                       logic [15:0] d, logic [31:0] addr, logic [31:0] data);
    @(negedge clk);
    reset = rst_n; in0 = a; in1 = b; in2 = c; in3 = d;
    config_addr = addr; config_data = data;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
  endtask

  task automatic rnd_cycle(logic [31:0] addr, logic [31:0] data, string name);
    drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), addr, data);
    check(name, dout, 16'(m_out[m_osel]));
    advance();
  endtask

  typedef struct {
    bit          rst_n;
    logic [15:0] i0, i1, i2, i3;
    logic [31:0] addr, data;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[18];
  localparam logic [31:0] c_NOP = 32'h0000_0009;

  initial begin
    logic [31:0] addr;
    logic [15:0] prev_sum;
    reset = 1'b0; config_addr = c_NOP; config_data = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    for (int t = 0; t < 4; t++) begin
      m_cfg[t] = 0; m_const[t] = 0; m_reg[t] = 0;
    end
    m_osel = 0;
    repeat (2) @(posedge clk);

    tbl[0]  = '{1'b0, 16'h0021, 16'h0000, 16'h0000, 16'h0000, c_NOP,    32'hFFFF_FFFF, 16'h0042};
    tbl[1]  = '{1'b1, 16'h1234, 16'h1111, 16'h0001, 16'h0002, ad(0, 0), 32'h0000_0008, 16'h2468};
    tbl[2]  = '{1'b1, 16'h1234, 16'h1111, 16'h0001, 16'h0002, ad(1, 0), 32'h0000_001A, 16'h2345};
    tbl[3]  = '{1'b1, 16'h1234, 16'h1111, 16'h0001, 16'h0002, ad(2, 0), 32'h0000_002C, 16'h2345};
    tbl[4]  = '{1'b1, 16'h1234, 16'h1111, 16'h0001, 16'h0002, ad(4, 0), 32'h0000_0002, 16'h2345};
    tbl[5]  = '{1'b1, 16'h1234, 16'h1111, 16'h0001, 16'h0002, c_NOP,    32'hFFFF_FFFF, 16'h2348};
    tbl[6]  = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, ad(9, 0), 32'h0000_0000, 16'h0000};
    tbl[7]  = '{1'b1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, ad(4, 5), 32'h0000_0000, 16'hA000};
    tbl[8]  = '{1'b1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, ad(2, 0), 32'h0000_042C, 16'h0A00};
    tbl[9]  = '{1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, c_NOP,    32'hFFFF_FFFF, 16'h0A00};
    tbl[10] = '{1'b1, 16'h0005, 16'h0005, 16'h0005, 16'h0005, ad(0, 0), 32'h0000_0004, 16'h000A};
    tbl[11] = '{1'b1, 16'h0055, 16'h0000, 16'h0000, 16'h0000, ad(4, 0), 32'h0000_0000, 16'h0014};
    tbl[12] = '{1'b1, 16'h0055, 16'h0003, 16'h0000, 16'h0000, ad(1, 1), 32'h0000_0100, 16'h0055};
    tbl[13] = '{1'b1, 16'h0055, 16'h0003, 16'h0000, 16'h0000, ad(1, 0), 32'h0000_004F, 16'h0055};
    tbl[14] = '{1'b1, 16'h0055, 16'h0003, 16'h0000, 16'h0000, ad(4, 0), 32'h0000_0001, 16'h0055};
    tbl[15] = '{1'b1, 16'h0055, 16'h0003, 16'h0000, 16'h0000, c_NOP,    32'hFFFF_FFFF, 16'h00FD};
    tbl[16] = '{1'b0, 16'h0021, 16'h0003, 16'h0000, 16'h0000, ad(4, 0), 32'h0000_0003, 16'h00FD};
    tbl[17] = '{1'b1, 16'h0021, 16'h0003, 16'h0000, 16'h0000, c_NOP,    32'hFFFF_FFFF, 16'h0042};

    for (int v = 0; v < 18; v++) begin
      drive(tbl[v].rst_n, tbl[v].i0, tbl[v].i1, tbl[v].i2, tbl[v].i3,
            tbl[v].addr, tbl[v].data);
      check($sformatf("vec%0d", v), dout, tbl[v].exp);
      advance();
    end

    // Sum of four with wrap, compared with both the model and a direct sum.
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, c_NOP, 32'h0);
    advance();
    rnd_cycle(ad(0, 0), 32'h008, "sum_cfg0");
    rnd_cycle(ad(1, 0), 32'h01A, "sum_cfg1");
    rnd_cycle(ad(2, 0), 32'h02C, "sum_cfg2");
    rnd_cycle(ad(4, 0), 32'h002, "sum_osel");
    for (int n = 0; n < 150; n++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), c_NOP, 32'h0);
      check("sum_model", dout, 16'(m_out[m_osel]));
      check("sum_direct", dout, in0 + in1 + in2 + in3);
      advance();
    end

    // Registered T2: result lags the four-input sum by one cycle.
    drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), ad(2, 0), 32'h42C);
    prev_sum = in0 + in1 + in2 + in3;
    advance();
    for (int n = 0; n < 100; n++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), c_NOP, 32'h0);
      check("latency", dout, prev_sum);
      prev_sum = in0 + in1 + in2 + in3;
      advance();
    end

    // Random configuration traffic, occasional resets.
    for (int n = 0; n < 500; n++) begin
      addr = ad(($urandom_range(0, 6) == 6) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5)),
                ($urandom_range(0, 3) == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2)));
      addr[23:16] = 8'($urandom);
      drive(($urandom_range(0, 39) != 0), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), addr, $urandom);
      check("random", dout, 16'(m_out[m_osel]));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
